// File: rtl/regbank_wb_arbiter.sv
// Two-port writeback arbiter for a 16x32 register bank: registered grant, round-robin on contention.
// Optional read-address bypass ports are enabled with the WB_BYPASS_EN macro.
module regbank_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        req0,
  input  logic [3:0]  wc0,
  input  logic [31:0] wd0,
  output logic        ack0,
  input  logic        req1,
  input  logic [3:0]  wc1,
  input  logic [31:0] wd1,
  output logic        ack1,
`ifdef WB_BYPASS_EN
  input  logic [3:0]  RA,
  input  logic [3:0]  RB,
  output logic        byp_a,
  output logic        byp_b,
  output logic [31:0] byp_data,
`endif
  output logic [3:0]  WC,
  output logic [31:0] WPC,
  output logic        W_RB
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q,  prio_d;   // 0: port 0 wins a tie, 1: port 1 wins
  logic [3:0]  wc_q,    wc_d;
  logic [31:0] wpc_q,   wpc_d;
  logic        ack0_q,  ack0_d;
  logic        ack1_q,  ack1_d;

  logic grant0, grant1, contend;

  always_comb begin
    contend = req0 && req1;
    grant0  = !hold && req0 && (!req1 || !prio_q);
    grant1  = !hold && req1 && (!req0 ||  prio_q);
  end

  // NOTE: every next-state signal gets a default before any branch, so no
  // path through this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = IDLE;
    prio_d  = prio_q;
    wc_d    = wc_q;
    wpc_d   = wpc_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;

    unique case (state_q)
      IDLE, WRITE: begin
        if (grant0) begin
          state_d = WRITE;
          wc_d    = wc0;
          wpc_d   = wd0;
          ack0_d  = 1'b1;
        end else if (grant1) begin
          state_d = WRITE;
          wc_d    = wc1;
          wpc_d   = wd1;
          ack1_d  = 1'b1;
        end
        // Hand the tie-break to the loser only after a contended grant.
        if (contend && (grant0 || grant1)) begin
          prio_d = grant0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      wc_q    <= 4'h0;
      wpc_q   <= 32'h0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      wc_q    <= wc_d;
      wpc_q   <= wpc_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign W_RB = (state_q == WRITE);
  assign WC   = wc_q;
  assign WPC  = wpc_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;

`ifdef WB_BYPASS_EN
  // Forward the in-flight write to read consumers addressing the same register.
  assign byp_a    = W_RB && (RA == wc_q);
  assign byp_b    = W_RB && (RB == wc_q);
  assign byp_data = wpc_q;
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Scoreboard bench for regbank_wb_arbiter: directed scenarios then randomized requesters.
// A behavioural arbiter model queues expected writes; a monitor pops them as the DUT writes.
module tb_regbank_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        req0, req1;
  logic [3:0]  wc0, wc1;
  logic [31:0] wd0, wd1;
  logic        ack0, ack1;
  logic [3:0]  WC;
  logic [31:0] WPC;
  logic        W_RB;
`ifdef WB_BYPASS_EN
  logic [3:0]  ra, rb;
  logic        byp_a, byp_b;
  logic [31:0] byp_data;
`endif

  regbank_wb_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .req0 (req0),
    .wc0  (wc0),
    .wd0  (wd0),
    .ack0 (ack0),
    .req1 (req1),
    .wc1  (wc1),
    .wd1  (wd1),
    .ack1 (ack1),
`ifdef WB_BYPASS_EN
    .RA       (ra),
    .RB       (rb),
    .byp_a    (byp_a),
    .byp_b    (byp_b),
    .byp_data (byp_data),
`endif
    .WC   (WC),
    .WPC  (WPC),
    .W_RB (W_RB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [3:0]  wc;
    logic [31:0] wd;
  } wr_t;

  wr_t         exp_q[$];
  logic        m_pref = 1'b0;   // port the model favours when both request
  logic [3:0]  last_wc = 4'h0;
  logic [31:0] last_wd = 32'h0;
  logic [31:0] dut_bank [16];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: whoever asks alone gets the bank; a tie goes to the
  // favoured port, and the other port is favoured for the next tie.
  always @(posedge clk) begin
    if (rst !== 1'b1 && hold === 1'b0 && (req0 || req1)) begin
      wr_t w;
      if (req0 && req1) begin
        w.port = m_pref;
        m_pref = ~m_pref;
      end else begin
        w.port = req1;
      end
      w.wc = w.port ? wc1 : wc0;
      w.wd = w.port ? wd1 : wd0;
      exp_q.push_back(w);
    end
  end

  // A reset cancels every write still owed and restores port-0 preference.
  always @(posedge rst) begin
    exp_q.delete();
    m_pref = 1'b0;
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("reset_outputs", {W_RB, ack0, ack1, WC, WPC}, '0);
      last_wc = 4'h0;
      last_wd = 32'h0;
    end else if (W_RB) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {WC, WPC}, '1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_ack", {ack0, ack1}, e.port ? 2'b01 : 2'b10);
        check("write_wc", WC, e.wc);
        check("write_wpc", WPC, e.wd);
`ifdef WB_BYPASS_EN
        check("bypass", {byp_a, byp_b, byp_data}, {ra == e.wc, rb == e.wc, e.wd});
`endif
        last_wc = e.wc;
        last_wd = e.wd;
        dut_bank[WC] = WPC;
      end
    end else begin
      check("idle_acks", {ack0, ack1}, 2'b00);
      check("idle_hold_regs", {WC, WPC}, {last_wc, last_wd});
      check("missing_write", exp_q.size(), 0);
`ifdef WB_BYPASS_EN
      check("idle_bypass", {byp_a, byp_b}, 2'b00);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic new_txn(input int port);
    if (port == 0) begin
      req0 = 1'b1; wc0 = 4'($urandom_range(0, 15)); wd0 = $urandom;
    end else begin
      req1 = 1'b1; wc1 = 4'($urandom_range(0, 15)); wd1 = $urandom;
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    req0 = 1'b0; wc0 = '0; wd0 = '0;
    req1 = 1'b0; wc1 = '0; wd1 = '0;
`ifdef WB_BYPASS_EN
    ra = 4'd3; rb = 4'd4;
`endif
    foreach (dut_bank[i]) dut_bank[i] = 32'h0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single request
    req0 = 1'b1; wc0 = 4'd5; wd0 = 32'hDEADBEEF;
    step();
    check("single_write", {W_RB, ack0, ack1, WC, WPC}, {3'b110, 4'd5, 32'hDEADBEEF});
    req0 = 1'b0;
    step();
    check("single_done", W_RB, 1'b0);

    // Contention: strict alternation starting with port 0
    req0 = 1'b1; wc0 = 4'd1; wd0 = 32'hA1;
    req1 = 1'b1; wc1 = 4'd2; wd1 = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      step();
      check("contend_seq", {W_RB, WC}, {1'b1, (i % 2 == 0) ? 4'd1 : 4'd2});
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Same destination: later grant wins the register
    req0 = 1'b1; wc0 = 4'd7; wd0 = 32'h11;
    req1 = 1'b1; wc1 = 4'd7; wd1 = 32'h22;
    step();
    check("samedst_first", {ack0, WPC}, {1'b1, 32'h11});
    req0 = 1'b0;
    step();
    check("samedst_second", {ack1, WPC}, {1'b1, 32'h22});
    req1 = 1'b0;
    step();
    check("samedst_bank_r7", dut_bank[7], 32'h22);

    // Hold: no grants for 3 cycles, then the favoured port (1) goes first
    hold = 1'b1;
    req0 = 1'b1; wc0 = 4'd3; wd0 = 32'h33;
    req1 = 1'b1; wc1 = 4'd4; wd1 = 32'h44;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_blocks", {W_RB, ack0, ack1}, 3'b000);
    end
    hold = 1'b0;
    step();
    check("hold_release", {ack1, WC}, {1'b1, 4'd4});
    req1 = 1'b0;
    step();
    check("hold_then_p0", {ack0, WC}, {1'b1, 4'd3});
    req0 = 1'b0;
    step();

    // Reset in the middle of a write
    req0 = 1'b1; wc0 = 4'd9; wd0 = 32'h99;
    step();
    check("pre_reset_write", W_RB, 1'b1);
    rst = 1'b1;
    #1;
    check("reset_cancels", {W_RB, WC, WPC}, '0);
    req0 = 1'b0;
    step();
    rst = 1'b0;
    req1 = 1'b1; wc1 = 4'd6; wd1 = 32'h66;
    step();
    check("post_reset_p1", {ack1, WC, WPC}, {1'b1, 4'd6, 32'h66});
    req1 = 1'b0;
    step();

    // Randomized requesters obeying the hold-until-ack handshake
    for (int c = 0; c < 1500; c++) begin
      hold = ($urandom_range(0, 9) == 0);
`ifdef WB_BYPASS_EN
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
`endif
      if (req0 && ack0) begin
        if ($urandom_range(0, 1) == 1) new_txn(0);
        else req0 = 1'b0;
      end else if (!req0 && $urandom_range(0, 2) != 0) begin
        new_txn(0);
      end
      if (req1 && ack1) begin
        if ($urandom_range(0, 1) == 1) new_txn(1);
        else req1 = 1'b0;
      end else if (!req1 && $urandom_range(0, 2) != 0) begin
        new_txn(1);
      end
      step();
    end

    hold = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();
    check("drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
REGBANK_WB_ARBITER -- requirements
Module: regbank_wb_arbiter

Interface
REQ-001 The block SHALL expose these ports (name, direction, width, meaning):
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- hold  input  1  control-unit stall; blocks new grants.
- req0  input  1  requester 0 (ALU writeback) request.
- wc0  input  4  requester 0 destination register.
- wd0  input  32  requester 0 write data.
- ack0  output  1  requester 0 accepted, one-cycle pulse.
- req1  input  1  requester 1 (memory load writeback) request.
- wc1  input  4  requester 1 destination register.
- wd1  input  32  requester 1 write data.
- ack1  output  1  requester 1 accepted, one-cycle pulse.
- WC  output  4  register bank write address.
- WPC  output  32  register bank write data.
- W_RB  output  1  register bank write enable.
REQ-002 The block SHALL use one clock, clk, with reset rst asynchronous and active-high.
REQ-003 All outputs SHALL be driven from flops, with no combinational input-to-output path, except the bypass outputs defined in REQ-020.

Function
REQ-004 A requester SHALL hold req, wc and wd stable from assertion until it samples its ack high.
REQ-005 The arbiter SHALL evaluate requests at each rising edge while hold=0.
- Exactly one requesting port: that port is granted.
- Both ports requesting: the port selected by the priority pointer prio is granted.
REQ-006 On a grant to port n, the block SHALL, in the same edge:
- register wcn into WC and wdn into WPC;
- set W_RB=1;
- set ackn=1 and the other ack to 0.
Write latency is 1 cycle from a sampled request to W_RB high.
REQ-007 W_RB, ack0 and ack1 SHALL each be high for exactly one cycle per grant.
- With no grant at an edge, all three SHALL be 0 and WC/WPC SHALL hold their values.
REQ-008 Throughput SHALL be one write per cycle; back-to-back grants are permitted.
- A requester keeping req high after its ack presents a new transaction.
REQ-009 prio SHALL toggle to the non-granted port after every cycle in which both ports requested and one was granted; otherwise it SHALL be unchanged.
REQ-010 With both ports continuously requesting, grants SHALL strictly alternate 0,1,0,1…, so neither port waits more than 1 cycle.
REQ-011 Same-destination conflict: if wc0==wc1 and both request, the two writes SHALL still issue in grant order on successive cycles.
- The later write determines the final register contents.
REQ-012 While hold=1, the block SHALL make no grants:
- W_RB, ack0 and ack1 SHALL be 0 from the next edge;
- prio SHALL be unchanged;
- requests are retained by the requesters.
REQ-013 Deasserting hold SHALL allow a grant at the first edge where hold=0 is sampled.
REQ-014 The internal state machine SHALL have two states:
- IDLE: no write issued this cycle.
- WRITE: W_RB high this cycle.
- Transition to WRITE on a grant; to IDLE otherwise.
- WRITE to WRITE is legal for back-to-back grants.

Reset
REQ-015 While rst=1, the block SHALL force: W_RB=0, ack0=0, ack1=0, WC=4'h0, WPC=32'h0, prio=port 0, state=IDLE.
REQ-016 Reset asserted in WRITE SHALL cancel the write immediately.
- No W_RB pulse SHALL appear after reset release for a pre-reset grant.
REQ-017 The first edge after reset release SHALL arbitrate normally, with port 0 preferred.

Configuration
REQ-018 Macro WB_BYPASS_EN SHALL control the bypass feature.
REQ-019 Without WB_BYPASS_EN, the interface SHALL be exactly that of REQ-001.
REQ-020 With WB_BYPASS_EN, the block SHALL add these ports:
- RA  input  4  bank read address A.
- RB  input  4  bank read address B.
- byp_a  output  1  combinational, =W_RB&&(RA==WC).
- byp_b  output  1  combinational, =W_RB&&(RB==WC).
- byp_data  output  32  =WPC.
This lets the datapath forward the in-flight write to its read consumers.

Verification
REQ-021 A bench SHALL cover these directed scenarios:
- Single request: req0=1, wc0=4'd5, wd0=32'hDEADBEEF -> next cycle W_RB=1, WC=5, WPC=32'hDEADBEEF, ack0=1; after dropping req0, W_RB=0.
- Contention: req0 and req1 held 4 cycles, wc0=1, wc1=2 -> WC sequence 1,2,1,2; ack pulses alternate; W_RB high all 4 cycles.
- Same destination: wc0=wc1=7, wd0=32'h11, wd1=32'h22, both requested once -> writes 32'h11 then 32'h22; bank R7 reads 32'h22.
- Hold: both requesting, hold=1 for 3 cycles -> W_RB=0 and no acks; after release, port prio is granted first.
- Reset mid-write: rst asserted in the cycle W_RB=1 -> W_RB=0 immediately, WC=0, WPC=0; after release with req1 only, port 1 is granted next cycle.
- WB_BYPASS_EN build: W_RB=1, WC=3, RA=3, RB=4 -> byp_a=1, byp_b=0, byp_data=WPC; without the macro, the ports are absent.
